// File: rtl/three_in_and_pkg.sv
// Shared types for the three_in_and slice: the combo index and mask used by the optional
// THREE_IN_AND_COVER_EN coverage tracker.
package three_in_and_pkg;

    localparam int COMBO_NUM = 8;

    typedef logic [2:0]           combo_idx_t;
    typedef logic [COMBO_NUM-1:0] combo_mask_t;

    // One-hot mask selecting the bit for operand combination {C,B,A}.
    function automatic combo_mask_t combo_onehot(input combo_idx_t idx);
        return combo_mask_t'(1) << idx;
    endfunction

endpackage

// File: rtl/three_in_and_and3_cell.sv
// Single-bit three-input AND leaf. It uses plain '&' so that X on any input propagates
// according to the normal Verilog rules.
module and3_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = a & b & c;

endmodule

// File: rtl/three_in_and.sv
// WIDTH-bit three-input AND with a combinational result and a valid-qualified registered copy.
// Defining THREE_IN_AND_COVER_EN adds the sticky combo_seen coverage mask.
module three_in_and
    import three_in_and_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
    output logic             out_valid,
`ifdef THREE_IN_AND_COVER_EN
    output logic [COMBO_NUM-1:0] combo_seen,
`endif
    output logic             all_ones
);

    // Each bit is fully independent, so the datapath is a row of identical cells.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and3_cell u_cell (
            .a (A[i]),
            .b (B[i]),
            .c (C[i]),
            .y (Y[i])
        );
    end

    // NOTE: Sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // Reset takes priority over in_valid, so a sample arriving during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Y_q <= Y;
            end
        end
    end

    assign all_ones = &Y_q;

`ifdef THREE_IN_AND_COVER_EN
    combo_idx_t combo_idx;

    assign combo_idx = {C[0], B[0], A[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            combo_seen <= '0;
        end else if (in_valid) begin
            combo_seen <= combo_seen | combo_onehot(combo_idx);
        end
    end
`endif

endmodule

// File: tb/tb_three_in_and.sv
// Randomized scoreboard bench for three_in_and, run at WIDTH=4 and WIDTH=1 side by side.
// The coverage mask is also checked when THREE_IN_AND_COVER_EN is defined.
module tb_three_in_and;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] A, B, C;
    logic [3:0] y4, yq4;
    logic       y1, yq1;
    logic       ov4, ov1, ao4, ao1;
`ifdef THREE_IN_AND_COVER_EN
    logic [7:0] cs4, cs1;
`endif

    always #5 clk = ~clk;

    three_in_and #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .in_valid(in_valid),
        .Y(y4), .Y_q(yq4), .out_valid(ov4),
`ifdef THREE_IN_AND_COVER_EN
        .combo_seen(cs4),
`endif
        .all_ones(ao4)
    );

    three_in_and #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .A(A[0]), .B(B[0]), .C(C[0]), .in_valid(in_valid),
        .Y(y1), .Y_q(yq1), .out_valid(ov1),
`ifdef THREE_IN_AND_COVER_EN
        .combo_seen(cs1),
`endif
        .all_ones(ao1)
    );

    typedef struct {
        logic       vld;
        logic [3:0] held;
        logic [7:0] seen;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state: last accepted result, and the set of combos seen since reset.
    logic [3:0] model_held = 4'h0;
    logic [7:0] model_seen = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    // Apply one cycle of stimulus, update the model, queue the expected registered response,
    // and confirm the combinational output has already settled before the next clock edge.
    task automatic drive(input logic r, input logic v, input logic [3:0] a, b, c);
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = v; A = a; B = b; C = c;
        if (r) begin
            model_held = 4'h0;
            model_seen = 8'h00;
        end else if (v) begin
            model_held = a & b & c;
            model_seen[{c[0], b[0], a[0]}] = 1'b1;
        end
        e.vld  = v && !r;
        e.held = model_held;
        e.seen = model_seen;
        sb.push_back(e);
        #1;
        check("y4_comb", 32'(y4), 32'(a & b & c));
        check("y1_comb", 32'(y1), 32'(a[0] & b[0] & c[0]));
    endtask

    // Monitor: one queued expectation per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out_valid4", 32'(ov4), 32'(e.vld));
                check("out_valid1", 32'(ov1), 32'(e.vld));
                check("y_q4", 32'(yq4), 32'(e.held));
                check("y_q1", 32'(yq1), 32'(e.held[0]));
                check("all_ones4", 32'(ao4), 32'(e.held == 4'hF));
                check("all_ones1", 32'(ao1), 32'(e.held[0]));
`ifdef THREE_IN_AND_COVER_EN
                check("combo_seen4", 32'(cs4), 32'(e.seen));
                check("combo_seen1", 32'(cs1), 32'(e.seen));
`endif
            end
        end
    end

    initial begin
        logic [3:0] bits;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; C = '0;

        // Reset held for two cycles with valid all-ones operands, then released.
        drive(1, 1, 4'hF, 4'hF, 4'hF);
        drive(1, 1, 4'hF, 4'hF, 4'hF);
        drive(0, 1, 4'hF, 4'hF, 4'hF);

        // Exhaustive combinational sweep with no sample taken.
        for (int k = 0; k < 8; k++) begin
            bits = 4'(k);
            drive(0, 0, {4{bits[0]}}, {4{bits[1]}}, {4{bits[2]}});
        end

        // Valid gating.
        drive(0, 1, 4'hF, 4'hA, 4'h6);
        drive(0, 0, 4'h0, 4'hA, 4'h6);
        drive(0, 0, 4'h0, 4'hA, 4'h6);

        // Back-to-back samples giving 1, 0, 1.
        drive(0, 1, 4'hF, 4'hF, 4'hF);
        drive(0, 1, 4'h0, 4'hF, 4'hF);
        drive(0, 1, 4'hF, 4'hF, 4'hF);
        drive(0, 0, 4'h0, 4'h0, 4'h0);

        // All eight combos, then reset, then only 3'b101 ({C,B,A}).
        for (int k = 0; k < 8; k++) begin
            bits = 4'(k);
            drive(0, 1, {4{bits[0]}}, {4{bits[1]}}, {4{bits[2]}});
        end
        drive(1, 0, 4'h0, 4'h0, 4'h0);
        drive(0, 1, 4'h1, 4'h0, 4'h1);
        drive(0, 0, 4'h0, 4'h0, 4'h0);

        // Random traffic with occasional reset pulses.
        for (int k = 0; k < 300; k++) begin
            drive(($urandom_range(0, 19) == 0), 1'($urandom),
                  4'($urandom), 4'($urandom), 4'($urandom));
        end
        drive(0, 0, 4'h0, 4'h0, 4'h0);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
